// File: rtl/lcd_nibble_sequencer_if.sv
// lcd_nibble_sequencer_if
// Groups the command handshake and the downstream I2C write-controller
// handshake used by lcd_nibble_sequencer.
//   cmd_valid/cmd_rs/cmd_byte/backlight : command offered to the sequencer
//   cmd_ready                           : sequencer can accept a command
//   i2c_start/i2c_data                  : transfer request and payload
//   i2c_busy/i2c_done/i2c_ack           : downstream controller status
// modport master : the sequencer side
// modport slave  : the command source / I2C controller side
interface lcd_nibble_sequencer_if;
  logic        cmd_valid;
  logic        cmd_rs;
  logic [7:0]  cmd_byte;
  logic        backlight;
  logic        cmd_ready;
  logic        i2c_start;
  logic [31:0] i2c_data;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_ack;

  modport master (
    input  cmd_valid, cmd_rs, cmd_byte, backlight,
    input  i2c_busy, i2c_done, i2c_ack,
    output cmd_ready, i2c_start, i2c_data
  );

  modport slave (
    output cmd_valid, cmd_rs, cmd_byte, backlight,
    output i2c_busy, i2c_done, i2c_ack,
    input  cmd_ready, i2c_start, i2c_data
  );
endinterface

// File: rtl/lcd_nibble_sequencer.sv
// lcd_nibble_sequencer
// Drives an HD44780-style LCD in 4-bit mode through an I2C port expander.
// After a power-up wait it plays a fixed init sequence, then accepts one
// instruction or character at a time and sends each byte as four expander
// writes (high nibble with EN pulse, then low nibble with EN pulse),
// followed by a settle delay.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   bus      : command + I2C handshake interface (master modport)
//   nack_err : sticky flag, a transfer was not acknowledged
//   busy     : high in every state except IDLE
module lcd_nibble_sequencer #(
  parameter logic [6:0] I2C_ADDR      = 7'h27,
  parameter int         SHORT_DELAY   = 2000,
  parameter int         LONG_DELAY    = 80000,
  parameter int         POWERUP_DELAY = 2000000
) (
  input  logic                          clk,
  input  logic                          reset,
  lcd_nibble_sequencer_if.master        bus,
  output logic                          nack_err,
  output logic                          busy
);

  typedef enum logic [2:0] {
    PWRUP  = 3'd0,
    IDLE   = 3'd1,
    XSTART = 3'd2,
    XWAIT  = 3'd3,
    NEXT   = 3'd4,
    DELAY  = 3'd5
  } state_t;

  localparam logic [23:0] PWR_LAST  = 24'(POWERUP_DELAY - 1);
  localparam logic [23:0] SHORT_CNT = 24'(SHORT_DELAY);
  localparam logic [23:0] LONG_CNT  = 24'(LONG_DELAY);
  localparam logic [2:0]  INIT_LAST = 3'd5;

  state_t      state;
  logic [23:0] pwr_cnt;
  logic [23:0] dly_cnt;
  logic [1:0]  nib_idx;
  logic [2:0]  init_idx;
  logic        in_init;
  logic        cur_rs;
  logic        cur_bl;
  logic [7:0]  cur_byte;
  logic [2:0]  next_init;

  assign next_init = init_idx + 3'd1;

  // Power-on init bytes: 8-bit wake-up twice, switch to 4-bit, 2-line
  // 5x8 font, display on, entry mode increment, clear.
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      3'd5:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Transfer payload for nibble index idx: bit 1 picks the low nibble,
  // bit 0 set means the EN-falling half of the pulse.
  function automatic logic [31:0] frame(input logic [7:0] b, input logic rs,
                                        input logic bl, input logic [1:0] idx);
    logic [3:0] nib;
    nib = idx[1] ? b[3:0] : b[7:4];
    return {17'd0, I2C_ADDR, nib, bl, ~idx[0], 1'b0, rs};
  endfunction

  // Clear and home instructions need the long settle time.
  function automatic logic is_slow(input logic [7:0] b, input logic rs);
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

  // Single FSM: every output is a register updated on state transitions so
  // i2c_data only moves when a new transfer is launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= PWRUP;
      pwr_cnt       <= '0;
      dly_cnt       <= '0;
      nib_idx       <= '0;
      init_idx      <= '0;
      in_init       <= 1'b0;
      cur_rs        <= 1'b0;
      cur_bl        <= 1'b0;
      cur_byte      <= '0;
      bus.cmd_ready <= 1'b0;
      bus.i2c_start <= 1'b0;
      bus.i2c_data  <= '0;
      nack_err      <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (state)
        PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            pwr_cnt       <= '0;
            in_init       <= 1'b1;
            init_idx      <= 3'd0;
            cur_rs        <= 1'b0;
            cur_bl        <= 1'b1;
            cur_byte      <= init_rom(3'd0);
            nib_idx       <= 2'd0;
            bus.i2c_data  <= frame(init_rom(3'd0), 1'b0, 1'b1, 2'd0);
            bus.i2c_start <= 1'b1;
            state         <= XSTART;
          end else begin
            pwr_cnt <= pwr_cnt + 24'd1;
          end
        end
        IDLE: begin
          if (bus.cmd_valid) begin
            cur_rs        <= bus.cmd_rs;
            cur_bl        <= bus.backlight;
            cur_byte      <= bus.cmd_byte;
            nib_idx       <= 2'd0;
            bus.i2c_data  <= frame(bus.cmd_byte, bus.cmd_rs, bus.backlight, 2'd0);
            bus.i2c_start <= 1'b1;
            bus.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= XSTART;
          end
        end
        XSTART: begin
          if (bus.i2c_busy) begin
            bus.i2c_start <= 1'b0;
            state         <= XWAIT;
          end
        end
        XWAIT: begin
          if (!bus.i2c_busy && bus.i2c_done) begin
            if (!bus.i2c_ack) nack_err <= 1'b1;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (nib_idx != 2'd3) begin
            nib_idx       <= nib_idx + 2'd1;
            bus.i2c_data  <= frame(cur_byte, cur_rs, cur_bl, nib_idx + 2'd1);
            bus.i2c_start <= 1'b1;
            state         <= XSTART;
          end else begin
            dly_cnt <= is_slow(cur_byte, cur_rs) ? LONG_CNT : SHORT_CNT;
            state   <= DELAY;
          end
        end
        DELAY: begin
          // The loaded count equals the number of cycles spent here; the
          // last cycle is the one where the counter steps to zero.
          if (dly_cnt <= 24'd1) begin
            dly_cnt <= '0;
            if (in_init && init_idx != INIT_LAST) begin
              init_idx      <= next_init;
              cur_byte      <= init_rom(next_init);
              nib_idx       <= 2'd0;
              bus.i2c_data  <= frame(init_rom(next_init), 1'b0, 1'b1, 2'd0);
              bus.i2c_start <= 1'b1;
              state         <= XSTART;
            end else begin
              in_init       <= 1'b0;
              bus.cmd_ready <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end
          end else begin
            dly_cnt <= dly_cnt - 24'd1;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// tb_lcd_nibble_sequencer
// Directed bench for lcd_nibble_sequencer with short delays
// (POWERUP_DELAY=10, SHORT_DELAY=4, LONG_DELAY=8) and a behavioural I2C
// responder that logs every transfer payload it is asked to send.
module tb_lcd_nibble_sequencer;

  localparam logic [31:0] ADDR_BITS = 32'h0000_2700;
  localparam logic [2:0]  ST_DELAY  = 3'd5;

  logic clk;
  logic reset;
  logic nack_err;
  logic busy;

  lcd_nibble_sequencer_if bus ();

  lcd_nibble_sequencer #(
    .I2C_ADDR      (7'h27),
    .SHORT_DELAY   (4),
    .LONG_DELAY    (8),
    .POWERUP_DELAY (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .nack_err (nack_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] xfer_log[$];
  int          busy_delay  = 0;
  int          nack_at     = 0;
  bit          hold_ok     = 1'b1;

  // Expected init payload bytes: 33, 32, 28, 0C, 06, 01 with BL=1, RS=0.
  logic [7:0] init_exp [24] = '{
    8'h3C, 8'h38, 8'h3C, 8'h38,
    8'h3C, 8'h38, 8'h2C, 8'h28,
    8'h2C, 8'h28, 8'h8C, 8'h88,
    8'h0C, 8'h08, 8'hCC, 8'hC8,
    8'h0C, 8'h08, 8'h6C, 8'h68,
    8'h0C, 8'h08, 8'h1C, 8'h18
  };

  // I2C responder: sees a start, optionally stalls busy while checking the
  // request is held, runs a short busy window, then reports done/ack.
  initial begin
    logic [31:0] cap;
    bus.i2c_busy = 1'b0;
    bus.i2c_done = 1'b1;
    bus.i2c_ack  = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (reset && bus.i2c_start) begin
        cap = bus.i2c_data;
        xfer_log.push_back(cap);
        for (int k = 0; k < busy_delay; k++) begin
          @(posedge clk); #1;
          if (bus.i2c_start !== 1'b1 || bus.i2c_data !== cap) hold_ok = 1'b0;
        end
        bus.i2c_busy = 1'b1;
        bus.i2c_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.i2c_busy = 1'b0;
        bus.i2c_done = 1'b1;
        bus.i2c_ack  = (nack_at == xfer_log.size()) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        bus.i2c_ack  = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command for a single cycle at the falling edge.
  task automatic applyStimulus(input logic rs, input logic [7:0] b,
                               input logic bl);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_byte  = b;
    bus.backlight = bl;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for cmd_ready, counting cycles spent in DELAY on the way.
  task automatic waitReady(input int limit, output int dly);
    int n;
    dly = 0;
    n   = 0;
    while (bus.cmd_ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      if (dut.state == ST_DELAY) dly++;
      n++;
    end
    checkOutput("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  task automatic checkLog4(input string tag, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
    logic [7:0] e [4];
    logic [31:0] obs;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    checkOutput({tag, "_count"}, 32'(xfer_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      obs = (i < xfer_log.size()) ? xfer_log[i] : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_xfer%0d", tag, i), obs, ADDR_BITS | {24'd0, e[i]});
    end
  endtask

  // Count rising edges from reset release until the first i2c_start.
  task automatic countPowerup(input string tag);
    int n;
    n = 0;
    while (bus.i2c_start !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(n), 32'd10);
  endtask

  initial begin
    int dly;
    int n;
    logic [31:0] obs;

    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_byte  = 8'h00;
    bus.backlight = 1'b0;
    reset         = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    checkOutput("rst_i2c_start", {31'd0, bus.i2c_start}, 32'd0);
    checkOutput("rst_i2c_data", bus.i2c_data, 32'd0);
    checkOutput("rst_nack_err", {31'd0, nack_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);

    // Power-up wait and full init sequence.
    @(negedge clk);
    reset = 1'b1;
    countPowerup("pwrup_cycles");
    waitReady(2000, dly);
    checkOutput("init_xfer_count", 32'(xfer_log.size()), 32'd24);
    for (int i = 0; i < 24; i++) begin
      obs = (i < xfer_log.size()) ? xfer_log[i] : 32'hFFFF_FFFF;
      checkOutput($sformatf("init_xfer%0d", i), obs, ADDR_BITS | {24'd0, init_exp[i]});
    end
    checkOutput("init_busy", {31'd0, busy}, 32'd0);
    checkOutput("init_nack", {31'd0, nack_err}, 32'd0);

    // Character 'A' with backlight on.
    xfer_log.delete();
    applyStimulus(1'b1, 8'h41, 1'b1);
    waitReady(500, dly);
    checkLog4("char_A", 8'h4D, 8'h49, 8'h1D, 8'h19);
    checkOutput("char_A_delay", 32'(dly), 32'd4);

    // Clear display, backlight off: long settle.
    xfer_log.delete();
    applyStimulus(1'b0, 8'h01, 1'b0);
    waitReady(500, dly);
    checkLog4("clear", 8'h04, 8'h00, 8'h14, 8'h10);
    checkOutput("clear_delay", 32'(dly), 32'd8);

    // Slow responder: request held, stray cmd_valid ignored.
    xfer_log.delete();
    busy_delay = 50;
    hold_ok    = 1'b1;
    applyStimulus(1'b1, 8'h42, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("hs_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    waitReady(2000, dly);
    busy_delay = 0;
    checkLog4("hs", 8'h4D, 8'h49, 8'h2D, 8'h29);
    checkOutput("hs_hold", {31'd0, hold_ok}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("hs_no_extra", 32'(xfer_log.size()), 32'd4);

    // NACK on the second transfer.
    xfer_log.delete();
    nack_at = 2;
    applyStimulus(1'b1, 8'h48, 1'b1);
    n = 0;
    while (xfer_log.size() < 2 && n < 200) begin @(negedge clk); n++; end
    checkOutput("nack_before", {31'd0, nack_err}, 32'd0);
    n = 0;
    while (xfer_log.size() < 3 && n < 200) begin @(negedge clk); n++; end
    checkOutput("nack_after_xfer2", {31'd0, nack_err}, 32'd1);
    waitReady(500, dly);
    nack_at = 0;
    checkLog4("nack", 8'h4D, 8'h49, 8'h8D, 8'h89);
    xfer_log.delete();
    applyStimulus(1'b0, 8'h0C, 1'b1);
    waitReady(500, dly);
    checkLog4("sticky", 8'h0C, 8'h08, 8'hCC, 8'hC8);
    checkOutput("nack_sticky", {31'd0, nack_err}, 32'd1);

    // Reset in the middle of the settle delay.
    applyStimulus(1'b1, 8'h41, 1'b1);
    n = 0;
    while (dut.state != ST_DELAY && n < 500) begin @(negedge clk); n++; end
    checkOutput("reach_delay", {29'd0, dut.state}, {29'd0, ST_DELAY});
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_start", {31'd0, bus.i2c_start}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    checkOutput("mid_rst_nack", {31'd0, nack_err}, 32'd0);
    xfer_log.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_held", 32'(xfer_log.size()), 32'd0);
    reset = 1'b1;
    countPowerup("repwrup_cycles");
    waitReady(2000, dly);
    checkOutput("reinit_count", 32'(xfer_log.size()), 32'd24);
    checkOutput("reinit_first", (xfer_log.size() > 0) ? xfer_log[0] : 32'hFFFF_FFFF,
                ADDR_BITS | 32'h3C);
    checkOutput("reinit_nack", {31'd0, nack_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_sequencer.md
LCD_NIBBLE_SEQUENCER -- requirements
Module: lcd_nibble_sequencer

Interface
REQ-001 Parameter I2C_ADDR, default 7'h27, 7-bit I2C address of the LCD port expander.
REQ-002 Parameter SHORT_DELAY, default 2000, settle cycles after a normal command or character.
REQ-003 Parameter LONG_DELAY, default 80000, settle cycles after clear (0x01) or home (0x02/0x03) commands.
REQ-004 Parameter POWERUP_DELAY, default 2000000, cycles from reset release to the first init transfer.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 cmd_valid  in  1  a command or character is offered.
REQ-008 cmd_rs  in  1  0 = instruction, 1 = display data.
REQ-009 cmd_byte  in  8  instruction or character code.
REQ-010 backlight  in  1  backlight state; sampled when a command is accepted.
REQ-011 cmd_ready  out  1  the block can accept a command this cycle.
REQ-012 i2c_start  out  1  transfer request to the downstream I2C LCD write controller.
REQ-013 i2c_data  out  32  transfer payload: [31:15]=0, [14:8]=I2C_ADDR, [7:0]=expander byte.
REQ-014 i2c_busy  in  1  downstream controller is transferring.
REQ-015 i2c_done  in  1  downstream controller is finished or idle.
REQ-016 i2c_ack  in  1  1 = both ACKs received on the last transfer.
REQ-017 nack_err  out  1  sticky flag: some transfer was not acknowledged.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 Expander byte bit map: [7:4]=nibble (D7..D4), [3]=backlight, [2]=EN, [1]=RW (always 0), [0]=RS.
REQ-020 Each byte is sent as 4 transfers, in order: high nibble EN=1, high nibble EN=0, low nibble EN=1, low nibble EN=0.
REQ-021 States: PWRUP, IDLE, XSTART, XWAIT, NEXT, DELAY; 2-bit nibble index selects the transfer (0..3).
REQ-022 PWRUP counts POWERUP_DELAY cycles, then loads init entry 0 and goes to XSTART.
REQ-023 Init ROM contents, all with RS=0 and backlight=1: 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01. Each entry is sent with its normal settle delay. After the last entry the block enters IDLE.
REQ-024 cmd_ready is 1 only in IDLE.
REQ-025 A command is accepted when cmd_valid=1 and cmd_ready=1 in the same cycle. cmd_rs, cmd_byte and backlight are latched, the nibble index is cleared, and the next state is XSTART.
REQ-026 cmd_valid is ignored when cmd_ready=0; no queueing.
REQ-027 XSTART drives i2c_start=1 with i2c_data stable, and holds both until i2c_busy=1 is sampled. It then moves to XWAIT.
REQ-028 i2c_start is 0 in all states other than XSTART.
REQ-029 i2c_data changes only on entry to XSTART.
REQ-030 XWAIT waits for i2c_busy=0 and i2c_done=1. In that cycle i2c_ack is sampled and nack_err is set if i2c_ack=0. The next state is NEXT.
REQ-031 A NACK does not abort the sequence; all 4 transfers and the delay still complete.
REQ-032 NEXT: if nibble index is less than 3, increment it and go to XSTART. Otherwise load the delay counter and go to DELAY.
REQ-033 Delay selection: LONG_DELAY if RS=0 and byte is 0x01, 0x02 or 0x03; SHORT_DELAY otherwise.
REQ-034 The delay counter is 24 bits and counts down to 0. DELAY exits on the cycle the count reaches 0: to the next init entry during init, else to IDLE.
REQ-035 nack_err clears only on reset.
REQ-036 Minimum command-to-command spacing equals 4 full transfers plus the settle delay.

Reset
REQ-037 While reset=0 the outputs are: state=PWRUP, cmd_ready=0, i2c_start=0, i2c_data=0, nack_err=0, busy=1; all counters and the init index are 0.
REQ-038 Reset asserted mid-transfer or mid-delay aborts immediately with no further i2c_start. After release the full PWRUP and init sequence re-runs.

Verification
REQ-039 Init, with POWERUP_DELAY=10, SHORT_DELAY=4, LONG_DELAY=8 and a behavioural I2C responder: first four i2c_data[7:0] values are 0x3C, 0x38, 0x3C, 0x38 with [14:8]=0x27. There are 24 transfers total, then cmd_ready=1.
REQ-040 Character: cmd_rs=1, cmd_byte=0x41, backlight=1 -> bytes 0x4D, 0x49, 0x1D, 0x19, then exactly 4 DELAY cycles before cmd_ready=1.
REQ-041 Clear: cmd_rs=0, cmd_byte=0x01, backlight=0 -> bytes 0x04, 0x00, 0x14, 0x10, then exactly 8 DELAY cycles.
REQ-042 Handshake: responder delays i2c_busy by 50 cycles -> i2c_start is held high and i2c_data stable for all 50 cycles. cmd_valid pulsed during the transfer is ignored.
REQ-043 NACK: responder returns i2c_ack=0 on transfer 2 -> nack_err=1 from the XWAIT exit onward, all 4 transfers still issued, and nack_err stays 1 through later commands until reset.
REQ-044 Reset mid-DELAY: reset=0 for 3 cycles -> i2c_start=0, cmd_ready=0, nack_err=0 immediately. After release the PWRUP count restarts from 0.
